// File: rtl/ctrl_seq_if.sv
// Sequencer-side bus for the RISC4B core: program memory fetch port plus the ALU issue/flag port.
interface ctrl_seq_if #(
  parameter int unsigned REG_SIZE = 4,
  parameter int unsigned PC_W     = 8
);
  localparam int unsigned IW = 12;

  logic [PC_W-1:0]     prog_addr;
  logic [IW-1:0]       prog_data;
  logic                prog_ready;
  logic [REG_SIZE-1:0] w_accu;
  logic                zero;
  logic                carry;
  logic [3:0]          opcode;
  logic [3:0]          operation;
  logic [REG_SIZE-1:0] alu_reg_in;

  modport master (
    output prog_addr, opcode, operation, alu_reg_in,
    input  prog_data, prog_ready, w_accu, zero, carry
  );

  modport slave (
    input  prog_addr, opcode, operation, alu_reg_in,
    output prog_data, prog_ready, w_accu, zero, carry
  );
endinterface

// File: rtl/ctrl_seq.sv
// RISC4B fetch/decode/issue sequencer: holds pc, ir and the register file, issues ALU ops,
// resolves branches on ALU flags and executes store/load-immediate/jump/halt locally.
module ctrl_seq #(
  parameter int unsigned REG_SIZE = 4,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned NREGS    = 16
) (
  input  logic         clk,
  input  logic         nreset,
  ctrl_seq_if.master   bus,
  output logic         halted
);
  localparam int unsigned IW = 12;

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [REG_SIZE-1:0] rf_q [NREGS];
  logic [REG_SIZE-1:0] rf_d [NREGS];
  logic [REG_SIZE-1:0] alu_reg_q, alu_reg_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [3:0]          operation_q, operation_d;
  logic                halted_q, halted_d;

  logic [3:0]          opc_c;
  logic [3:0]          rd_c;
  logic                is_alu_c;
  logic [PC_W-1:0]     target_c;

  assign opc_c    = ir_q[11:8];
  assign rd_c     = ir_q[3:0];
  assign is_alu_c = (opc_c[3:2] == 2'b10);
  assign target_c = PC_W'(ir_q[7:0]);

  // ALU strobes are registered on entry to EXEC so they are high for exactly that cycle
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    rf_d        = rf_q;
    alu_reg_d   = alu_reg_q;
    opcode_d    = 4'h0;
    operation_d = 4'h0;
    case (state_q)
      S_FETCH: begin
        if (bus.prog_ready) begin
          ir_d    = bus.prog_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_reg_d   = rf_q[rd_c];
        opcode_d    = is_alu_c ? opc_c : 4'h0;
        operation_d = ir_q[7:4];
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_W'(1);
        case (opc_c)
          4'h1: rf_d[rd_c] = bus.w_accu;
          4'h5: rf_d[rd_c] = REG_SIZE'(ir_q[7:4]);
          4'h2: pc_d = target_c;
          4'h3: if (bus.zero)  pc_d = target_c;
          4'h4: if (bus.carry) pc_d = target_c;
          4'hF: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      default: state_d = S_HALT;
    endcase
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      alu_reg_q   <= '0;
      opcode_q    <= 4'h0;
      operation_q <= 4'h0;
      halted_q    <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      alu_reg_q   <= alu_reg_d;
      opcode_q    <= opcode_d;
      operation_q <= operation_d;
      halted_q    <= halted_d;
      rf_q        <= rf_d;
    end
  end

  assign bus.prog_addr  = pc_q;
  assign bus.opcode     = opcode_q;
  assign bus.operation  = operation_q;
  assign bus.alu_reg_in = alu_reg_q;
  assign halted         = halted_q;
endmodule
